// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage MIPS pipeline registers.
//   - Bit positions of the WB and M control fields.
//   - NOP instruction encoding (all zeros, i.e. sll $0,$0,0).
//   - Default widths for the WB/M control fields and register addresses.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Write-back control field bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Memory control field bit positions
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // Instruction word inserted by a flush
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Default field widths
    localparam int WB_W_DEF    = 2;
    localparam int M_W_DEF     = 3;
    localparam int REG_AW_DEF  = 5;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one on each clock where inc is high and
// sticks at its all-ones maximum instead of wrapping.
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, clears the count
//   inc      in   count this cycle
//   count    out  W-bit saturating count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/ex_mem_stage_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_reg
// EX/MEM pipeline register with hold (stall), bubble insertion (flush),
// valid-gated forwarding outputs for the hazard unit and saturating
// stall/flush event counters.
//
// Per-edge action priority: flush > stall > load.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   stall, flush              hazard-unit controls, sampled at the edge
//   in_valid                  EX stage holds a real instruction
//   inst_in/alu_in/store_in   instruction, ALU result, store data
//   dest_in/wb_in/m_in        destination register, WB and M controls
//   out_valid, *_out          registered copies of the above
//   fwd_en/fwd_dest/fwd_data  forwarding source, derived from registers only
//   stall_cnt/flush_cnt       saturating event counts
// -----------------------------------------------------------------------------
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int INST_W = 32,
    parameter int REG_AW = REG_AW_DEF,
    parameter int WB_W   = WB_W_DEF,
    parameter int M_W    = M_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] inst_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [M_W-1:0]    m_in,
    output logic              out_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] store_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [WB_W-1:0]   wb_out,
    output logic [M_W-1:0]    m_out,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_store;
    logic [REG_AW-1:0] r_dest;
    logic [WB_W-1:0]   r_wb;
    logic [M_W-1:0]    r_m;

    logic              w_stall_inc;
    logic              w_fwd_en;

    // Field registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_alu   <= '0;
            r_store <= '0;
            r_dest  <= '0;
            r_wb    <= '0;
            r_m     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_inst  <= INST_W'(NOP_INST);
            r_alu   <= '0;
            r_store <= '0;
            r_dest  <= '0;
            r_wb    <= '0;
            r_m     <= '0;
        end else if (!stall) begin
            r_valid <= in_valid;
            r_inst  <= inst_in;
            r_alu   <= alu_in;
            r_store <= store_in;
            r_dest  <= dest_in;
            // An invalid slot still captures its data but must never write
            // the register file or memory downstream.
            r_wb    <= in_valid ? wb_in : '0;
            r_m     <= in_valid ? m_in  : '0;
        end
    end

    // A cycle with both stall and flush is accounted as a flush only.
    assign w_stall_inc = stall & ~flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush),
        .count   (flush_cnt)
    );

    // Forwarding is derived from the registered stage only; writes to $0
    // are never forwarded.
    assign w_fwd_en = r_valid & r_wb[WB_REGWRITE] & (r_dest != '0);

    assign out_valid = r_valid;
    assign inst_out  = r_inst;
    assign alu_out   = r_alu;
    assign store_out = r_store;
    assign dest_out  = r_dest;
    assign wb_out    = r_wb;
    assign m_out     = r_m;
    assign fwd_en    = w_fwd_en;
    assign fwd_dest  = w_fwd_en ? r_dest : '0;
    assign fwd_data  = r_alu;

endmodule : ex_mem_stage_reg

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst_in = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] store_in = '0;
    logic [4:0]  dest_in = '0;
    logic [1:0]  wb_in = '0;
    logic [2:0]  m_in = '0;

    // Default-parameter instance
    logic        out_valid;
    logic [31:0] inst_out, alu_out, store_out, fwd_data;
    logic [4:0]  dest_out, fwd_dest;
    logic [1:0]  wb_out;
    logic [2:0]  m_out;
    logic        fwd_en;
    logic [15:0] stall_cnt, flush_cnt;

    // CNT_W=2 instance, same stimulus
    logic        out_valid2;
    logic [31:0] inst_out2, alu_out2, store_out2, fwd_data2;
    logic [4:0]  dest_out2, fwd_dest2;
    logic [1:0]  wb_out2;
    logic [2:0]  m_out2;
    logic        fwd_en2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int n_total = 0;
    int n_pass  = 0;

    ex_mem_stage_reg dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .inst_in(inst_in), .alu_in(alu_in),
        .store_in(store_in), .dest_in(dest_in), .wb_in(wb_in), .m_in(m_in),
        .out_valid(out_valid), .inst_out(inst_out), .alu_out(alu_out),
        .store_out(store_out), .dest_out(dest_out), .wb_out(wb_out),
        .m_out(m_out), .fwd_en(fwd_en), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ex_mem_stage_reg #(.CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .inst_in(inst_in), .alu_in(alu_in),
        .store_in(store_in), .dest_in(dest_in), .wb_in(wb_in), .m_in(m_in),
        .out_valid(out_valid2), .inst_out(inst_out2), .alu_out(alu_out2),
        .store_out(store_out2), .dest_out(dest_out2), .wb_out(wb_out2),
        .m_out(m_out2), .fwd_en(fwd_en2), .fwd_dest(fwd_dest2),
        .fwd_data(fwd_data2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic        e_valid = 1'b0;
    logic [31:0] e_inst = '0, e_alu = '0, e_store = '0;
    logic [4:0]  e_dest = '0;
    logic [1:0]  e_wb = '0;
    logic [2:0]  e_m = '0;
    int          e_sc = 0, e_fc = 0;

    function automatic int sat_add(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= 1'b0; e_inst <= '0; e_alu <= '0; e_store <= '0;
            e_dest <= '0; e_wb <= '0; e_m <= '0; e_sc <= 0; e_fc <= 0;
        end else if (flush) begin
            e_valid <= 1'b0; e_inst <= '0; e_alu <= '0; e_store <= '0;
            e_dest <= '0; e_wb <= '0; e_m <= '0;
            e_fc <= e_fc + 1;
        end else if (stall) begin
            e_sc <= e_sc + 1;
        end else begin
            e_valid <= in_valid; e_inst <= inst_in; e_alu <= alu_in;
            e_store <= store_in; e_dest <= dest_in;
            e_wb <= in_valid ? wb_in : 2'b00;
            e_m  <= in_valid ? m_in  : 3'b000;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic        x_fen;
        int          c16_s, c16_f, c2_s, c2_f;
        x_fen = e_valid && e_wb[1] && (e_dest != 0);
        c16_s = (e_sc > 65535) ? 65535 : e_sc;
        c16_f = (e_fc > 65535) ? 65535 : e_fc;
        c2_s  = (e_sc > 3) ? 3 : e_sc;
        c2_f  = (e_fc > 3) ? 3 : e_fc;
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("inst_out",  64'(inst_out),  64'(e_inst));
        chk("alu_out",   64'(alu_out),   64'(e_alu));
        chk("store_out", 64'(store_out), 64'(e_store));
        chk("dest_out",  64'(dest_out),  64'(e_dest));
        chk("wb_out",    64'(wb_out),    64'(e_wb));
        chk("m_out",     64'(m_out),     64'(e_m));
        chk("fwd_en",    64'(fwd_en),    64'(x_fen));
        chk("fwd_dest",  64'(fwd_dest),  x_fen ? 64'(e_dest) : 64'd0);
        chk("fwd_data",  64'(fwd_data),  64'(e_alu));
        chk("stall_cnt", 64'(stall_cnt), 64'(c16_s));
        chk("flush_cnt", 64'(flush_cnt), 64'(c16_f));
        chk("out_valid2", 64'(out_valid2), 64'(e_valid));
        chk("inst_out2",  64'(inst_out2),  64'(e_inst));
        chk("alu_out2",   64'(alu_out2),   64'(e_alu));
        chk("store_out2", 64'(store_out2), 64'(e_store));
        chk("dest_out2",  64'(dest_out2),  64'(e_dest));
        chk("wb_out2",    64'(wb_out2),    64'(e_wb));
        chk("m_out2",     64'(m_out2),     64'(e_m));
        chk("fwd_en2",    64'(fwd_en2),    64'(x_fen));
        chk("fwd_dest2",  64'(fwd_dest2),  x_fen ? 64'(e_dest) : 64'd0);
        chk("fwd_data2",  64'(fwd_data2),  64'(e_alu));
        chk("stall_cnt2", 64'(stall_cnt2), 64'(c2_s));
        chk("flush_cnt2", 64'(flush_cnt2), 64'(c2_f));
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge: drive inputs, let one rising edge pass,
    // return at the following falling edge.
    task automatic cyc(input logic v, input logic [31:0] alu, input logic [4:0] d,
                       input logic [1:0] wb, input logic [2:0] m,
                       input logic st, input logic fl);
        in_valid = v; alu_in = alu; dest_in = d; wb_in = wb; m_in = m;
        inst_in = $urandom; store_in = $urandom;
        stall = st; flush = fl;
        @(posedge clock);
        @(negedge clock);
        $display("cyc v=%0b alu=%h dest=%0d wb=%b m=%b stall=%0b flush=%0b -> ov=%0b alu_out=%h fwd_en=%0b fwd_dest=%0d sc=%0d fc=%0d",
                 v, alu, d, wb, m, st, fl, out_valid, alu_out, fwd_en, fwd_dest, stall_cnt, flush_cnt);
    endtask

    task automatic rand_cyc();
        logic [4:0] d;
        d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cyc(1'($urandom), $urandom, d, 2'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    endtask

    logic [31:0] held_alu;
    logic [31:0] held_inst;

    initial begin
        // Reset held through the first rising edge
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu_out",   64'(alu_out),   64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        reset_n = 1'b1;

        // Forwarding cases
        cyc(1'b1, 32'h0000_1234, 5'd8, 2'b10, 3'b000, 1'b0, 1'b0);
        chk("lit_out_valid", 64'(out_valid), 64'd1);
        chk("lit_alu_out",   64'(alu_out),   64'h1234);
        chk("lit_fwd_en",    64'(fwd_en),    64'd1);
        chk("lit_fwd_dest",  64'(fwd_dest),  64'd8);
        chk("lit_fwd_data",  64'(fwd_data),  64'h1234);
        cyc(1'b1, 32'h0000_0055, 5'd0, 2'b10, 3'b000, 1'b0, 1'b0);
        chk("lit_fwd_en_r0",   64'(fwd_en),   64'd0);
        chk("lit_fwd_dest_r0", 64'(fwd_dest), 64'd0);
        cyc(1'b1, 32'h0000_0066, 5'd9, 2'b00, 3'b000, 1'b0, 1'b0);
        chk("lit_fwd_en_nowr", 64'(fwd_en), 64'd0);

        // Store-type entry, then hold it for three cycles
        cyc(1'b1, 32'hCAFE_0001, 5'd3, 2'b10, 3'b001, 1'b0, 1'b0);
        held_alu  = 32'hCAFE_0001;
        held_inst = inst_out;
        for (int i = 0; i < 3; i++) rand_cyc_stall();
        chk("lit_stall_hold_alu",  64'(alu_out),   64'(held_alu));
        chk("lit_stall_hold_inst", 64'(inst_out),  64'(held_inst));
        chk("lit_stall_hold_m",    64'(m_out),     64'd1);
        chk("lit_stall_cnt3",      64'(stall_cnt), 64'd3);

        // Flush wins over a simultaneous stall
        cyc(1'b1, 32'h1111_2222, 5'd4, 2'b11, 3'b111, 1'b1, 1'b1);
        chk("lit_flush_valid", 64'(out_valid), 64'd0);
        chk("lit_flush_m",     64'(m_out),     64'd0);
        chk("lit_flush_wb",    64'(wb_out),    64'd0);
        chk("lit_flush_inst",  64'(inst_out),  64'd0);
        chk("lit_flush_cnt",   64'(flush_cnt), 64'd1);
        chk("lit_flush_scnt",  64'(stall_cnt), 64'd3);

        // Invalid load: controls masked, data captured
        cyc(1'b0, 32'hABCD_0123, 5'd7, 2'b11, 3'b010, 1'b0, 1'b0);
        chk("lit_bub_wb",    64'(wb_out),    64'd0);
        chk("lit_bub_m",     64'(m_out),     64'd0);
        chk("lit_bub_valid", 64'(out_valid), 64'd0);
        chk("lit_bub_alu",   64'(alu_out),   64'hABCD_0123);

        // Five more stalls: narrow counter saturates
        for (int i = 0; i < 5; i++) rand_cyc_stall();
        chk("lit_sat2_stall", 64'(stall_cnt2), 64'd3);
        chk("lit_16_stall",   64'(stall_cnt),  64'd8);

        // Random traffic
        for (int i = 0; i < 400; i++) rand_cyc();

        // Asynchronous reset in the middle of a stalled cycle
        stall = 1'b1; flush = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("lit_arst_valid", 64'(out_valid), 64'd0);
        chk("lit_arst_inst",  64'(inst_out),  64'd0);
        chk("lit_arst_alu",   64'(alu_out),   64'd0);
        chk("lit_arst_wb",    64'(wb_out),    64'd0);
        chk("lit_arst_fwd",   64'(fwd_en),    64'd0);
        chk("lit_arst_fdest", 64'(fwd_dest),  64'd0);
        chk("lit_arst_sc",    64'(stall_cnt), 64'd0);
        chk("lit_arst_fc",    64'(flush_cnt), 64'd0);
        chk("lit_arst_sc2",   64'(stall_cnt2), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1'b1, 32'h0000_0042, 5'd5, 2'b10, 3'b000, 1'b0, 1'b0);
        chk("lit_post_rst_fwd", 64'(fwd_dest), 64'd5);
        for (int i = 0; i < 20; i++) rand_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic rand_cyc_stall();
        cyc(1'($urandom), $urandom, 5'($urandom), 2'($urandom), 3'($urandom), 1'b1, 1'b0);
    endtask

endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

Parametrised EX/MEM pipeline register for the five-stage MIPS core. It sits between the ALU stage and the data-memory stage. It carries the instruction, ALU result, store data, destination register and the WB/M control fields, plus a valid bit. Over the single-register version it adds stall (hold), flush (bubble insertion), valid-gated forwarding outputs for the hazard unit, and saturating stall/flush event counters.

## Interface
- DATA_W, 32, ALU result and store-data width
- INST_W, 32, instruction word width
- REG_AW, 5, register-address width
- WB_W, 2, write-back control field width
- M_W, 3, memory control field width
- CNT_W, 16, event counter width
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all contents this cycle
- flush  in  1  replace contents with a bubble this cycle
- in_valid  in  1  EX stage holds a real instruction
- inst_in  in  INST_W  instruction from EX
- alu_in  in  DATA_W  ALU result
- store_in  in  DATA_W  rt value for stores
- dest_in  in  REG_AW  destination register
- wb_in  in  WB_W  write-back controls (bit WB_REGWRITE = RegWrite)
- m_in  in  M_W  memory controls
- out_valid  out  1  register holds a real instruction
- inst_out, alu_out, store_out, dest_out, wb_out, m_out  out  as inputs  registered copies
- fwd_en  out  1  forwarding source valid
- fwd_dest  out  REG_AW  forwarding destination, 0 when fwd_en=0
- fwd_data  out  DATA_W  equals alu_out
- stall_cnt, flush_cnt  out  CNT_W  saturating event counts

## Operation
- Each rising edge applies exactly one action, in this priority order: flush > stall > load.
- Flush: out_valid←0. inst, alu, store, dest, wb and m all←0, so inst_out=0 is the NOP encoding. flush_cnt increments.
- Stall (flush=0): every register holds its value. stall_cnt increments.
- Load (flush=0, stall=0): out_valid←in_valid and all data fields←inputs. When in_valid=0, wb_out and m_out←0 so a bubble never writes a register or memory; data fields are still captured.
- Counters saturate at 2^CNT_W−1 and do not wrap. A flush cycle with stall=1 counts only as a flush.
- fwd_en = out_valid & wb_out[WB_REGWRITE] & (dest_out != 0).
- fwd_dest = fwd_en ? dest_out : 0. fwd_data = alu_out.
- The forwarding outputs are combinational from the registers only and never from the inputs.
- Reset (reset_n=0, at any time and asynchronously): every output register and both counters←0. Forwarding outputs therefore read 0.

## Timing
- Latency is one cycle from input capture to output.
- The forwarding outputs are valid in the same cycle as the registered fields.
- stall and flush are sampled at the rising edge. They take effect on outputs after that edge.
- A reset asserted mid-stall or mid-flush clears everything immediately.
- After reset_n deasserts, the first rising edge performs a normal action.
- No handshake; the hazard unit owns stall and flush.

## Structure
- Shared package pipe_pkg holds:
  - bit indices WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0;
  - NOP_INST = 0;
  - default widths for WB_W, M_W and REG_AW.
- One sub-module, sat_counter (parameter W; ports clock, reset_n, inc, count), is instantiated twice for stall_cnt and flush_cnt.
- The field registers are a single always block with async reset.

## Test plan
- Reset, then load in_valid=1, alu_in=0x0000_1234, dest_in=8, wb_in=2'b10 → next cycle:
  - out_valid=1, alu_out=0x1234;
  - fwd_en=1, fwd_dest=8, fwd_data=0x1234.
- Load with dest_in=0 and wb_in=2'b10 → fwd_en=0, fwd_dest=0. Load with dest_in=9 and wb_in=2'b00 → fwd_en=0.
- Stall held for 3 cycles while inputs change → all outputs unchanged and stall_cnt=3.
- stall=1 and flush=1 together on an entry with m_out=3'b001 → next cycle:
  - out_valid=0, m_out=0, wb_out=0, inst_out=0;
  - flush_cnt=1, stall_cnt unchanged.
- Load in_valid=0 with wb_in=2'b11 and m_in=3'b010 → wb_out=0, m_out=0, out_valid=0, alu_out equal to alu_in.
- With CNT_W=2, hold stall for 5 cycles → stall_cnt stays at 3. Assert reset_n=0 mid-cycle → all outputs read 0 immediately, without waiting for a clock edge.
